slsu: RTL and testbench

//  Load/store unit: initiator side of the data-memory port (sdatamem-compatible strobes, combinational read).

---
 rtl/slsu.sv | 208 ++++++++++++++++++++
 tb/tb_slsu.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slsu.sv
// Load/store unit: drives a combinational-read data memory, checks bounds and
// alignment, splits misaligned accesses into byte accesses and extends load data.
module slsu #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_SIZE      = 1024,
  parameter int MISALIGN_TRAP = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_load_i,
  input  logic                  req_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [1:0]            mem_size_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [4:0]            resp_rd_o,
  output logic [1:0]            resp_err_o
);
  localparam int DW = DATA_WIDTH;
  localparam bit TRAP = (MISALIGN_TRAP != 0);
  localparam logic [DW:0] LIMIT = (DW+1)'(MEM_SIZE - 3);
  localparam logic [1:0] ERR_OK = 2'b00, ERR_MIS = 2'b01, ERR_FAULT = 2'b10, ERR_ILL = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

  state_t          state_q;
  logic            load_q;
  logic [2:0]      funct3_q;
  logic [DW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [4:0]      rd_q;
  logic [1:0]      cnt_q;
  logic [1:0]      last_q;
  logic [DW-1:0]   buf_q;

  logic            req_ready_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic [1:0]      mem_size_q;
  logic [DW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            resp_valid_q;
  logic [DW-1:0]   resp_data_q;
  logic [4:0]      resp_rd_q;
  logic [1:0]      resp_err_q;

  logic            accept;
  logic [1:0]      nb_m1;
  logic            illegal;
  logic            misaligned;
  logic [DW:0]     end_addr;
  logic            fault;
  logic [DW-1:0]   wnext;
  logic [DW-1:0]   buf_d;

  function automatic logic [DW-1:0] extend(input logic [2:0] f3, input logic [DW-1:0] raw);
    case (f3)
      3'd0:    return {{(DW-8){raw[7]}}, raw[7:0]};
      3'd1:    return {{(DW-16){raw[15]}}, raw[15:0]};
      3'd4:    return {{(DW-8){1'b0}}, raw[7:0]};
      3'd5:    return {{(DW-16){1'b0}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign accept = req_valid_i & req_ready_q;

  always_comb begin
    case (req_funct3_i[1:0])
      2'b00:   nb_m1 = 2'd0;
      2'b01:   nb_m1 = 2'd1;
      default: nb_m1 = 2'd3;
    endcase
  end

  assign illegal = (req_load_i == req_store_i) ||
                   (req_load_i && (req_funct3_i == 3'd3 || req_funct3_i == 3'd6 || req_funct3_i == 3'd7)) ||
                   (req_store_i && req_funct3_i > 3'd2);
  assign misaligned = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                      (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
  // 33-bit sum so an access wrapping past the top of the address space still faults
  assign end_addr = {1'b0, req_addr_i} + {{(DW-1){1'b0}}, nb_m1};
  assign fault    = misaligned ? (end_addr >= LIMIT) : ({1'b0, req_addr_i} >= LIMIT);

  assign wnext = wdata_q >> (8 * (int'(cnt_q) + 1));
  assign buf_d = buf_q | ({{(DW-8){1'b0}}, mem_rdata_i[7:0]} << (8 * int'(cnt_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      load_q       <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      last_q       <= '0;
      buf_q        <= '0;
      req_ready_q  <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_size_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            load_q      <= req_load_i;
            funct3_q    <= req_funct3_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            rd_q        <= req_rd_i;
            cnt_q       <= '0;
            last_q      <= nb_m1;
            buf_q       <= '0;
            req_ready_q <= 1'b0;
            if (illegal || (misaligned && TRAP) || fault) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= illegal ? ERR_ILL : (misaligned && TRAP) ? ERR_MIS : ERR_FAULT;
            end else begin
              state_q     <= misaligned ? SPLIT : ACCESS;
              mem_read_q  <= req_load_i;
              mem_write_q <= req_store_i;
              mem_addr_q  <= req_addr_i;
              mem_size_q  <= misaligned ? 2'b00 : req_funct3_i[1:0];
              if (!req_store_i)
                mem_wdata_q <= '0;
              else if (misaligned)
                mem_wdata_q <= {{(DW-8){1'b0}}, req_wdata_i[7:0]};
              else
                mem_wdata_q <= req_wdata_i;
            end
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          mem_size_q   <= '0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= ERR_OK;
          resp_data_q  <= load_q ? extend(funct3_q, mem_rdata_i) : '0;
          resp_rd_q    <= load_q ? rd_q : '0;
        end
        SPLIT: begin
          buf_q <= buf_d;
          if (cnt_q == last_q) begin
            state_q      <= RESP;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ERR_OK;
            resp_data_q  <= load_q ? extend(funct3_q, buf_d) : '0;
            resp_rd_q    <= load_q ? rd_q : '0;
          end else begin
            cnt_q      <= cnt_q + 2'd1;
            mem_addr_q <= addr_q + {{(DW-2){1'b0}}, cnt_q} + 1'b1;
            if (!load_q)
              mem_wdata_q <= {{(DW-8){1'b0}}, wnext[7:0]};
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_size_o   = mem_size_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_rd_o    = resp_rd_q;
  assign resp_err_o   = resp_err_q;
endmodule

// File: tb/tb_slsu.sv
// Bench for slsu: two instances (split mode and trap mode) each on a byte-array
// memory, scoreboarded against a request-level reference model.
module tb_slsu;
  localparam int MEM = 1024;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  err;
    int          nwr;
    int          nrd;
    int          lat;
    int          acc;
    logic [31:0] a0;
    logic [1:0]  sz0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_load   [2];
  logic        req_store  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [4:0]  req_rd     [2];
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [1:0]  mem_size   [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_data  [2];
  logic [4:0]  resp_rd    [2];
  logic [1:0]  resp_err   [2];

  for (genvar u = 0; u < 2; u++) begin : g
    slsu #(.DATA_WIDTH(32), .MEM_SIZE(MEM), .MISALIGN_TRAP(u)) dut (
      .clk(clk), .rst_n(rst_n[u]),
      .req_valid_i(req_valid[u]), .req_ready_o(req_ready[u]),
      .req_load_i(req_load[u]), .req_store_i(req_store[u]),
      .req_funct3_i(req_funct3[u]), .req_addr_i(req_addr[u]),
      .req_wdata_i(req_wdata[u]), .req_rd_i(req_rd[u]),
      .mem_read_o(mem_read[u]), .mem_write_o(mem_write[u]),
      .mem_size_o(mem_size[u]), .mem_addr_o(mem_addr[u]),
      .mem_wdata_o(mem_wdata[u]), .mem_rdata_i(mem_rdata[u]),
      .resp_valid_o(resp_valid[u]), .resp_ready_i(resp_ready[u]),
      .resp_data_o(resp_data[u]), .resp_rd_o(resp_rd[u]), .resp_err_o(resp_err[u])
    );
  end

  int vectors = 0;
  int checks  = 0;
  int fails   = 0;
  int ncyc    = 0;
  int rr_mode [2];
  exp_t sb0[$];
  exp_t sb1[$];

  logic [7:0] bmem [2][MEM];
  logic [7:0] rmem [2][MEM];

  function automatic logic [7:0] init_byte(int u, int i);
    return 8'((i * 73 + u * 29 + 5) ^ (i >> 3));
  endfunction

  // Memory as seen by the unit: combinational read, sign-extending its own result
  function automatic logic [31:0] mem_rd(int u, logic [31:0] a, logic [1:0] sz);
    logic [31:0] v;
    longint idx;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      idx = longint'(a) + k;
      if (idx < MEM) v[8*k +: 8] = bmem[u][int'(idx)];
    end
    case (sz)
      2'b00:   v = {{24{v[7]}}, v[7:0]};
      2'b01:   v = {{16{v[15]}}, v[15:0]};
      default: ;
    endcase
    return v;
  endfunction

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      mem_rdata[u] = '0;
      mem_rdata[u] = mem_rd(u, mem_addr[u], mem_size[u]);
    end
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      if (mem_write[u])
        for (int k = 0; k < 4; k++)
          if (k < (mem_size[u] == 2'b00 ? 1 : mem_size[u] == 2'b01 ? 2 : 4) &&
              longint'(mem_addr[u]) + k < MEM)
            bmem[u][int'(mem_addr[u]) + k] <= mem_wdata[u][8*k +: 8];
  end

  always @(posedge clk) ncyc <= ncyc + 1;

  // Reference model: whole-request semantics on a byte array
  function automatic exp_t model(int u, bit ld, bit st, logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] wd, logic [4:0] rd);
    exp_t e;
    int nb;
    bit ill, mis;
    longint last;
    logic [31:0] v;
    e = '{data: 0, rd: 0, err: 0, nwr: 0, nrd: 0, lat: 1, acc: 0, a0: a, sz0: 0};
    nb   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill  = (ld == st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2);
    mis  = (a % nb) != 0;
    last = longint'(a) + nb - 1;
    e.sz0 = mis ? 2'b00 : f3[1:0];
    if (ill) e.err = 2'b11;
    else if (mis && u == 1) e.err = 2'b01;
    else if ((mis ? last : longint'(a)) >= MEM - 3) e.err = 2'b10;
    else begin
      e.lat = mis ? nb + 1 : 2;
      if (st) begin
        e.nwr = mis ? nb : 1;
        for (int k = 0; k < nb; k++) rmem[u][int'(a) + k] = wd[8*k +: 8];
      end else begin
        e.nrd = mis ? nb : 1;
        v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = rmem[u][int'(a) + k];
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        e.data = v;
        e.rd   = rd;
      end
    end
    return e;
  endfunction

  function automatic void push(int u, exp_t e);
    if (u == 0) sb0.push_back(e); else sb1.push_back(e);
  endfunction
  function automatic int sbsize(int u);
    return (u == 0) ? sb0.size() : sb1.size();
  endfunction
  function automatic exp_t pop(int u);
    if (u == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  task automatic chk(string nm, int u, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s u%0d: got 0x%0h, required 0x%0h", nm, u, act, req);
    end
  endtask

  task automatic issue(int u, bit ld, bit st, logic [2:0] f3, logic [31:0] a,
                       logic [31:0] wd, logic [4:0] rd);
    exp_t e;
    int t;
    @(negedge clk);
    req_valid[u] = 1'b1; req_load[u] = ld; req_store[u] = st;
    req_funct3[u] = f3; req_addr[u] = a; req_wdata[u] = wd; req_rd[u] = rd;
    t = 0;
    while (!req_ready[u] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[u]) begin
      checks++; fails++;
      $display("FAIL accept u%0d: req_ready_o stayed 0, required 1 within 100 cycles", u);
      req_valid[u] = 1'b0;
      return;
    end
    e = model(u, ld, st, f3, a, wd, rd);
    e.acc = ncyc;
    push(u, e);
    vectors++;
    @(negedge clk);
    req_valid[u] = 1'b0;
  endtask

  task automatic drain(int u);
    int t;
    t = 0;
    while (sbsize(u) > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sbsize(u) > 0) begin
      fails++;
      $display("FAIL drain u%0d: %0d responses outstanding, required 0", u, sbsize(u));
    end
  endtask

  task automatic rnd(int u);
    int r, s;
    bit ld, st;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    s = $urandom_range(0, 15);
    ld = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : (r % 2 == 0);
    st = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : (r % 2 == 1);
    a  = (s == 0) ? $urandom : (s < 3) ? 32'($urandom_range(1000, 1023)) : 32'($urandom_range(0, 1023));
    issue(u, ld, st, 3'($urandom_range(0, 7)), a, $urandom, 5'($urandom_range(0, 31)));
  endtask

  // resp_ready changes just after the rising edge so the monitor sees it settled
  initial forever begin
    @(posedge clk);
    #2;
    for (int u = 0; u < 2; u++)
      resp_ready[u] = (rr_mode[u] == 0) ? 1'b1 : (rr_mode[u] == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  int          nwr   [2];
  int          nrd   [2];
  int          first [2];
  bit          seen  [2];
  bit          held  [2];
  logic [31:0] a0    [2];
  logic [1:0]  sz0   [2];
  logic [31:0] pdata [2];
  logic [1:0]  perr  [2];
  logic [4:0]  prd   [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n[u]) begin
        nwr[u] = 0; nrd[u] = 0; seen[u] = 0; held[u] = 0;
      end else begin
        if (mem_read[u] || mem_write[u]) begin
          if (nwr[u] + nrd[u] == 0) begin
            a0[u] = mem_addr[u]; sz0[u] = mem_size[u];
          end
          if (mem_write[u]) nwr[u]++;
          if (mem_read[u]) nrd[u]++;
        end
        if (held[u]) begin
          chk("hold_valid", u, 32'(resp_valid[u]), 32'd1);
          chk("hold_data", u, resp_data[u], pdata[u]);
          chk("hold_err", u, 32'(resp_err[u]), 32'(perr[u]));
          chk("hold_rd", u, 32'(resp_rd[u]), 32'(prd[u]));
          chk("busy_ready", u, 32'(req_ready[u]), 32'd0);
        end
        if (resp_valid[u]) chk("resp_strobe", u, 32'(mem_read[u] | mem_write[u]), 32'd0);
        if (resp_valid[u] && !seen[u]) begin
          seen[u] = 1; first[u] = ncyc;
        end
        if (resp_valid[u] && resp_ready[u]) begin
          if (sbsize(u) == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_resp u%0d: got response err %0d, required none", u, resp_err[u]);
          end else begin
            exp_t e;
            e = pop(u);
            chk("data", u, resp_data[u], e.data);
            chk("rd", u, 32'(resp_rd[u]), 32'(e.rd));
            chk("err", u, 32'(resp_err[u]), 32'(e.err));
            chk("writes", u, nwr[u], e.nwr);
            chk("reads", u, nrd[u], e.nrd);
            chk("latency", u, first[u] - e.acc, e.lat);
            if (e.nwr + e.nrd > 0) begin
              chk("first_addr", u, a0[u], e.a0);
              chk("size", u, 32'(sz0[u]), 32'(e.sz0));
            end
          end
          nwr[u] = 0; nrd[u] = 0; seen[u] = 0;
        end
        held[u]  = resp_valid[u] && !resp_ready[u];
        pdata[u] = resp_data[u]; perr[u] = resp_err[u]; prd[u] = resp_rd[u];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion before 500 us");
    $fatal(1);
  end

  initial begin
    logic [7:0] saved [3];
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; req_valid[u] = 1'b0; req_load[u] = 1'b0; req_store[u] = 1'b0;
      req_funct3[u] = '0; req_addr[u] = '0; req_wdata[u] = '0; req_rd[u] = '0;
      rr_mode[u] = 0; resp_ready[u] = 1'b1;
      for (int i = 0; i < MEM; i++) begin
        bmem[u][i] = init_byte(u, i);
        rmem[u][i] = init_byte(u, i);
      end
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_req_ready", u, 32'(req_ready[u]), 32'd1);
      chk("rst_resp_valid", u, 32'(resp_valid[u]), 32'd0);
      chk("rst_strobes", u, 32'(mem_read[u] | mem_write[u]), 32'd0);
      chk("rst_resp_data", u, resp_data[u], 32'd0);
      chk("rst_mem_addr", u, mem_addr[u], 32'd0);
      rst_n[u] = 1'b1;
    end

    // Split-mode instance: aligned, byte/half extension, misaligned split
    issue(0, 0, 1, 3'd2, 32'h10, 32'h12345678, 5'd0);
    issue(0, 1, 0, 3'd2, 32'h10, 32'h0, 5'd3);
    issue(0, 0, 1, 3'd0, 32'h12, 32'h0, 5'd0);
    issue(0, 0, 1, 3'd0, 32'h13, 32'h80, 5'd0);
    issue(0, 1, 0, 3'd0, 32'h13, 32'h0, 5'd4);
    issue(0, 1, 0, 3'd4, 32'h13, 32'h0, 5'd5);
    issue(0, 1, 0, 3'd5, 32'h12, 32'h0, 5'd6);
    issue(0, 0, 1, 3'd2, 32'h11, 32'hA1B2C3D4, 5'd0);
    issue(0, 1, 0, 3'd2, 32'h11, 32'h0, 5'd7);
    issue(0, 1, 0, 3'd1, 32'h3FC, 32'h0, 5'd8);
    issue(0, 1, 0, 3'd5, 32'hFFFF_FFFF, 32'h0, 5'd8);

    // Trap-mode instance: misaligned, fault and illegal classes
    issue(1, 1, 0, 3'd1, 32'h3, 32'h0, 5'd8);
    issue(1, 1, 0, 3'd2, 32'h3FD, 32'h0, 5'd9);
    issue(1, 1, 0, 3'd3, 32'h20, 32'h0, 5'd10);
    issue(1, 0, 1, 3'd4, 32'h20, 32'h0, 5'd10);
    issue(1, 1, 1, 3'd2, 32'h20, 32'h0, 5'd10);
    issue(1, 0, 0, 3'd2, 32'h20, 32'h0, 5'd10);
    issue(1, 0, 1, 3'd1, 32'h22, 32'hBEEF, 5'd0);
    issue(1, 1, 0, 3'd1, 32'h22, 32'h0, 5'd11);
    drain(0);
    drain(1);

    // Writeback stall: response must hold while resp_ready_i is low
    rr_mode[0] = 2;
    issue(0, 1, 0, 3'd2, 32'h10, 32'h0, 5'd9);
    repeat (5) @(negedge clk);
    rr_mode[0] = 0;
    drain(0);

    // Asynchronous reset in the middle of a split store
    for (int k = 0; k < 3; k++) saved[k] = rmem[0][34 + k];
    issue(0, 0, 1, 3'd2, 32'h21, 32'hCAFEBABE, 5'd0);
    @(posedge clk);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("midrst_write", 0, 32'(mem_write[0]), 32'd0);
    chk("midrst_read", 0, 32'(mem_read[0]), 32'd0);
    chk("midrst_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("midrst_resp", 0, 32'(resp_valid[0]), 32'd0);
    for (int k = 0; k < 3; k++) rmem[0][34 + k] = saved[k];
    sb0.delete();
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    issue(0, 1, 0, 3'd2, 32'h20, 32'h0, 5'd12);
    issue(0, 1, 0, 3'd2, 32'h24, 32'h0, 5'd13);
    drain(0);

    // Randomized traffic on both instances with random writeback stalls
    rr_mode[0] = 1;
    rr_mode[1] = 1;
    fork
      begin
        for (int i = 0; i < 150; i++) rnd(0);
      end
      begin
        for (int i = 0; i < 150; i++) rnd(1);
      end
    join
    drain(0);
    drain(1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
